spin_unrotator_pipe: RTL and testbench

- Pipelined inverse spin-bus rotator for the Ising array datapath.
- Rotates a SPINS-lane bus toward lower lane index: out[j] = in[(j + s) mod SPINS]. This undoes the forward rotation applied ahead of the coupling array, so spin/weight lanes return to their home positions.
- One register per log2 shift stage, with a valid/ready handshake at each end.
- Includes an auto-sweep offset counter for stepping a bus through every rotation.

---
 rtl/spin_unrotator_pipe.sv | 123 ++++++++++++
 tb/tb_spin_unrotator_pipe.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spin_unrotator_pipe.sv
// Pipelined inverse spin-bus rotator: bus_out[j] = bus_in[(j + ctrl) mod SPINS], one register per log2 stage.
// Define UNROT_SWEEP_EN to generate the auto-sweep offset counter (in_auto, offset_clr, sweep_done).
module spin_unrotator_pipe #(
    parameter int WIDTH = 32,
    parameter int SPINS = 32,
    localparam int CW = $clog2(SPINS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [SPINS-1:0][WIDTH-1:0] bus_in,
    input  logic [CW-1:0]               in_ctrl,
    input  logic                        in_auto,
    input  logic                        offset_clr,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [SPINS-1:0][WIDTH-1:0] bus_out,
    output logic [CW-1:0]               out_ctrl,
    output logic                        sweep_done
);

    localparam logic [CW:0] SPINS_W = (CW+1)'(SPINS);

    typedef logic [SPINS-1:0][WIDTH-1:0] bus_t;

    // Index k is the input side of stage k; index CW is the output register of the last stage.
    bus_t          d_s   [CW+1];
    logic [CW-1:0] c_s   [CW+1];
    logic [CW:0]   v_s;
    logic [CW:0]   t_s;
    logic [CW:0]   rdy_s;

    assign d_s[0]   = bus_in;
    assign v_s[0]   = in_valid;
    assign rdy_s[CW] = out_ready;
    assign in_ready = rdy_s[0];

`ifdef UNROT_SWEEP_EN
    localparam logic [CW-1:0] LAST_OFF = CW'(SPINS - 1);

    logic [CW-1:0] offset_r;
    logic          accept_auto_s;

    assign accept_auto_s = in_valid && rdy_s[0] && in_auto;
    assign c_s[0]        = in_auto ? offset_r : in_ctrl;
    assign t_s[0]        = in_auto && (offset_r == LAST_OFF);

    // Sweep offset: clear wins over increment; a beat taken in the clearing cycle still used the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            offset_r <= '0;
        end else if (offset_clr) begin
            offset_r <= '0;
        end else if (accept_auto_s) begin
            offset_r <= (offset_r == LAST_OFF) ? '0 : offset_r + CW'(1);
        end else begin
            offset_r <= offset_r;
        end
    end
`else
    logic unused_s;

    assign unused_s = in_auto ^ offset_clr;
    assign c_s[0]   = in_ctrl;
    assign t_s[0]   = 1'b0;
`endif

    for (genvar k = 0; k < CW; k++) begin : g_stage
        localparam int AMT = (1 << k) % SPINS;

        bus_t          rot_s;
        bus_t          sel_s;
        logic [CW-1:0] cnx_s;
        bus_t          d_r;
        logic [CW-1:0] c_r;
        logic          v_r;
        logic          t_r;

        for (genvar j = 0; j < SPINS; j++) begin : g_lane
            localparam int SRC = (j + AMT) % SPINS;
            assign rot_s[j] = d_s[k][SRC];
        end

        assign sel_s = c_s[k][k] ? rot_s : d_s[k];

        // The last stage stores the ctrl reduced mod SPINS; ctrl < 2^CW < 2*SPINS so one subtract suffices.
        if (k == CW - 1) begin : g_reduce
            assign cnx_s = ({1'b0, c_s[k]} >= SPINS_W) ? CW'({1'b0, c_s[k]} - SPINS_W) : c_s[k];
        end else begin : g_pass
            assign cnx_s = c_s[k];
        end

        assign rdy_s[k]  = !v_s[k+1] || rdy_s[k+1];
        assign d_s[k+1]  = d_r;
        assign c_s[k+1]  = c_r;
        assign v_s[k+1]  = v_r;
        assign t_s[k+1]  = t_r;

        // Stage register: advances when downstream has room; payload only moves with a real beat.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_r <= 1'b0;
                d_r <= '0;
                c_r <= '0;
                t_r <= 1'b0;
            end else if (rdy_s[k]) begin
                v_r <= v_s[k];
                if (v_s[k]) begin
                    d_r <= sel_s;
                    c_r <= cnx_s;
                    t_r <= t_s[k];
                end
            end
        end
    end

    assign out_valid  = v_s[CW];
    assign bus_out    = d_s[CW];
    assign out_ctrl   = c_s[CW];
    assign sweep_done = t_s[CW];

endmodule

// File: tb/tb_spin_unrotator_pipe.sv
// Self-checking bench for spin_unrotator_pipe: a SPINS=4 and a SPINS=5 instance, directed tables plus random traffic.
module tb_spin_unrotator_pipe;

`ifdef UNROT_SWEEP_EN
    localparam bit SWEEP = 1'b1;
`else
    localparam bit SWEEP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic iv4, ir4, a4, clr4, ov4, or4, sd4;
    logic [3:0][7:0] bi4, bo4;
    logic [1:0] c4, oc4;

    logic iv5, ir5, a5, clr5, ov5, or5, sd5;
    logic [4:0][7:0] bi5, bo5;
    logic [2:0] c5, oc5;

    spin_unrotator_pipe #(.WIDTH(8), .SPINS(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .bus_in(bi4),
        .in_ctrl(c4), .in_auto(a4), .offset_clr(clr4), .out_valid(ov4),
        .out_ready(or4), .bus_out(bo4), .out_ctrl(oc4), .sweep_done(sd4));

    spin_unrotator_pipe #(.WIDTH(8), .SPINS(5)) u5 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv5), .in_ready(ir5), .bus_in(bi5),
        .in_ctrl(c5), .in_auto(a5), .offset_clr(clr5), .out_valid(ov5),
        .out_ready(or5), .bus_out(bo5), .out_ctrl(oc5), .sweep_done(sd5));

    typedef struct {
        logic [39:0] bus;
        int          ctrl;
        bit          sw;
    } beat_t;

    typedef struct {
        bit          sel5;
        logic [39:0] bin;
        int          ctrl;
        logic [39:0] bexp;
        int          cexp;
    } vec_t;

    beat_t q4[$];
    beat_t q5[$];
    int    obs_c[$];
    bit    obs_s[$];
    int    off4, off5, n_out4;
    int    n_checks, n_err;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: lane j of the result is lane (j + c) mod s of the input.
    function automatic logic [39:0] rot_ref(input logic [39:0] b, input int s, input int c);
        logic [39:0] r;
        r = '0;
        for (int j = 0; j < s; j++) r[j*8 +: 8] = b[((j + c) % s)*8 +: 8];
        return r;
    endfunction

    function automatic beat_t mk(input int s, input logic [39:0] b, input int ic, input bit au, input int off);
        beat_t e;
        int    c;
        c      = (SWEEP && au) ? off : ic;
        e.bus  = rot_ref(b, s, c);
        e.ctrl = c % s;
        e.sw   = SWEEP && au && (off == s - 1);
        return e;
    endfunction

    function automatic int next_off(input int s, input bit acc, input bit au, input bit clr, input int off);
        if (!SWEEP || clr) return 0;
        if (acc && au) return (off + 1) % s;
        return off;
    endfunction

    // One clock: settle, score outputs and record accepted inputs, then advance to the next falling edge.
    task automatic tick();
        beat_t e;
        bit    acc4, acc5;
        #1;
        acc4 = iv4 && ir4;
        acc5 = iv5 && ir5;
        if (ov4 && or4) begin
            if (q4.size() == 0) check("u4_unexpected_out", ov4, 0);
            else begin
                e = q4.pop_front();
                check("u4_bus", bo4, e.bus);
                check("u4_ctrl", oc4, e.ctrl);
                check("u4_sweep", sd4, e.sw);
            end
            obs_c.push_back(int'(oc4));
            obs_s.push_back(sd4);
            n_out4++;
        end
        if (ov5 && or5) begin
            if (q5.size() == 0) check("u5_unexpected_out", ov5, 0);
            else begin
                e = q5.pop_front();
                check("u5_bus", bo5, e.bus);
                check("u5_ctrl", oc5, e.ctrl);
                check("u5_sweep", sd5, e.sw);
            end
        end
        if (acc4) q4.push_back(mk(4, {8'h00, bi4}, int'(c4), a4, off4));
        if (acc5) q5.push_back(mk(5, bi5, int'(c5), a5, off5));
        off4 = next_off(4, acc4, a4, clr4, off4);
        off5 = next_off(5, acc5, a5, clr5, off5);
        @(posedge clk);
        @(negedge clk);
    endtask

    vec_t        tbl[10];
    logic [31:0] bp[3];
    int          ec[5];
    bit          es[5];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat, n0, idx, exp_first;
        bit  saw_block, acc;

        tbl[0] = '{1'b0, 40'h0003020100, 1, 40'h0000030201, 1};
        tbl[1] = '{1'b0, 40'h0003020100, 0, 40'h0003020100, 0};
        tbl[2] = '{1'b0, 40'h0003020100, 2, 40'h0001000302, 2};
        tbl[3] = '{1'b0, 40'h0003020100, 3, 40'h0002010003, 3};
        tbl[4] = '{1'b0, 40'h00D3C2B1A0, 3, 40'h00C2B1A0D3, 3};
        tbl[5] = '{1'b1, 40'h0403020100, 6, 40'h0004030201, 1};
        tbl[6] = '{1'b1, 40'h0403020100, 7, 40'h0100040302, 2};
        tbl[7] = '{1'b1, 40'h0403020100, 4, 40'h0302010004, 4};
        tbl[8] = '{1'b1, 40'h0403020100, 5, 40'h0403020100, 0};
        tbl[9] = '{1'b1, 40'h4433221100, 3, 40'h2211004433, 3};

        n_checks = 0; n_err = 0; off4 = 0; off5 = 0; n_out4 = 0;
        iv4 = 0; bi4 = '0; c4 = '0; a4 = 0; clr4 = 0; or4 = 1;
        iv5 = 0; bi5 = '0; c5 = '0; a5 = 0; clr5 = 0; or5 = 1;
        rst_n = 0;

        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid4", ov4, 0);
        check("rst_bus4", bo4, 0);
        check("rst_ctrl4", oc4, 0);
        check("rst_sweep4", sd4, 0);
        check("rst_out_valid5", ov5, 0);
        check("rst_bus5", bo5, 0);
        rst_n = 1;
        #1;
        check("rst_in_ready4", ir4, 1);
        check("rst_in_ready5", ir5, 1);
        @(negedge clk);

        // Single beats with fixed expectations: latency, rotated lanes, reduced ctrl.
        foreach (tbl[i]) begin
            if (tbl[i].sel5) begin bi5 = tbl[i].bin; c5 = 3'(tbl[i].ctrl); iv5 = 1; end
            else begin bi4 = tbl[i].bin[31:0]; c4 = 2'(tbl[i].ctrl); iv4 = 1; end
            tick();
            iv4 = 0; iv5 = 0;
            lat = 1;
            while (!(tbl[i].sel5 ? ov5 : ov4) && lat < 10) begin tick(); lat++; end
            check("tbl_latency", lat, tbl[i].sel5 ? 3 : 2);
            check("tbl_bus", tbl[i].sel5 ? bo5 : {8'h00, bo4}, tbl[i].bexp);
            check("tbl_ctrl", tbl[i].sel5 ? int'(oc5) : int'(oc4), tbl[i].cexp);
            tick();
        end

        // Back-to-back sweep of in_ctrl 0..3: one output per clock, in order.
        obs_c.delete(); obs_s.delete(); n0 = n_out4;
        for (int k = 0; k < 4; k++) begin bi4 = 32'h03020100; c4 = 2'(k); iv4 = 1; tick(); end
        iv4 = 0;
        tick(); tick();
        check("burst_count", n_out4 - n0, 4);
        for (int k = 0; k < 4; k++) check("burst_ctrl_order", obs_c[k], k);

        // Backpressure: A,B,C with out_ready low for 5 cycles.
        bp[0] = 32'hA3A2A1A0; bp[1] = 32'hB3B2B1B0; bp[2] = 32'hC3C2C1C0;
        n0 = n_out4; idx = 0; saw_block = 0;
        for (int cyc = 0; cyc < 40 && (n_out4 - n0) < 3; cyc++) begin
            or4 = (cyc >= 5);
            if (idx < 3) begin iv4 = 1; bi4 = bp[idx]; c4 = 2'd1; end
            else iv4 = 0;
            #1;
            acc = iv4 && ir4;
            if (iv4 && !ir4) saw_block = 1;
            tick();
            if (acc) idx++;
            if (cyc >= 1 && cyc < 5) begin
                check("bp_out_valid_held", ov4, 1);
                check("bp_hold_bus", bo4, 32'hA0A3A2A1);
            end
        end
        iv4 = 0; or4 = 1;
        check("bp_in_ready_dropped", saw_block, 1);
        check("bp_all_out", n_out4 - n0, 3);

`ifdef UNROT_SWEEP_EN
        // Auto sweep: five beats wrap the counter at SPINS.
        obs_c.delete(); obs_s.delete();
        ec = '{0, 1, 2, 3, 0}; es = '{0, 0, 0, 1, 0};
        a4 = 1;
        for (int k = 0; k < 5; k++) begin iv4 = 1; bi4 = $urandom; c4 = 2'd3; tick(); end
        iv4 = 0; a4 = 0;
        repeat (3) tick();
        check("sweep_count", obs_c.size(), 5);
        for (int k = 0; k < 5; k++) begin
            check("sweep_ctrl", obs_c[k], ec[k]);
            check("sweep_done", obs_s[k], es[k]);
        end
        clr4 = 1; tick(); clr4 = 0;
        obs_c.delete(); obs_s.delete();
        ec = '{0, 1, 0, 1, 2};
        a4 = 1;
        for (int k = 0; k < 5; k++) begin iv4 = 1; clr4 = (k == 1); bi4 = $urandom; tick(); end
        iv4 = 0; a4 = 0; clr4 = 0;
        repeat (3) tick();
        for (int k = 0; k < 5; k++) begin
            check("clr_ctrl", obs_c[k], ec[k]);
            check("clr_sweep", obs_s[k], 0);
        end
`else
        // Without the sweep feature, in_auto and offset_clr have no effect.
        obs_c.delete(); obs_s.delete();
        ec = '{2, 3, 1, 0, 0};
        a4 = 1;
        for (int k = 0; k < 3; k++) begin iv4 = 1; clr4 = (k == 1); c4 = 2'(ec[k]); bi4 = $urandom; tick(); end
        iv4 = 0; a4 = 0; clr4 = 0;
        repeat (3) tick();
        for (int k = 0; k < 3; k++) begin
            check("noauto_ctrl", obs_c[k], ec[k]);
            check("noauto_sweep", obs_s[k], 0);
        end
`endif

        // Reset with two beats in flight.
        a4 = 1; c4 = 2'd1; bi4 = 32'h11223344;
        iv4 = 1; tick(); tick(); iv4 = 0;
        rst_n = 0;
        #1;
        check("midrst_out_valid4", ov4, 0);
        check("midrst_bus4", bo4, 0);
        check("midrst_ctrl4", oc4, 0);
        check("midrst_out_valid5", ov5, 0);
        q4.delete(); q5.delete(); off4 = 0; off5 = 0;
        @(negedge clk);
        rst_n = 1;
        for (int k = 0; k < 4; k++) begin tick(); check("midrst_no_ghost", ov4, 0); end
        obs_c.delete(); obs_s.delete();
        exp_first = SWEEP ? 0 : 3;
        c4 = 2'd3; a4 = 1; iv4 = 1; tick(); iv4 = 0; a4 = 0;
        repeat (3) tick();
        check("midrst_out_count", obs_c.size(), 1);
        check("midrst_counter_restart", obs_c[0], exp_first);

        // Random traffic on both instances against the queue model.
        for (int cyc = 0; cyc < 400; cyc++) begin
            iv4 = ($urandom_range(0, 3) != 0); bi4 = $urandom; c4 = 2'($urandom_range(0, 3));
            a4 = 1'($urandom_range(0, 1)); clr4 = ($urandom_range(0, 15) == 0); or4 = ($urandom_range(0, 3) != 0);
            iv5 = ($urandom_range(0, 3) != 0); bi5 = 40'({$urandom, $urandom}); c5 = 3'($urandom_range(0, 7));
            a5 = 1'($urandom_range(0, 1)); clr5 = ($urandom_range(0, 15) == 0); or5 = ($urandom_range(0, 3) != 0);
            tick();
        end
        iv4 = 0; iv5 = 0; clr4 = 0; clr5 = 0; or4 = 1; or5 = 1;
        for (int k = 0; k < 20 && (q4.size() != 0 || q5.size() != 0); k++) tick();
        check("drain_q4", q4.size(), 0);
        check("drain_q5", q5.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
